// File: rtl/simon64_128_encrypt.sv
// Iterative SIMON64/128 encryptor: one round per clock, key schedule expanded on the fly.
// Define SIMON_RK_TAP_EN to expose the current round key (rk_tap) and round index (rk_idx).
module simon64_128_encrypt (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  plaintext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  ciphertext
`ifdef SIMON_RK_TAP_EN
  ,
  output logic [31:0]  rk_tap,
  output logic [5:0]   rk_idx
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  // z3 sequence, z[0] is the leftmost bit
  localparam logic [0:61] Z = 62'b11011011101011000110010111100000010010001010011100110100001111;
  localparam logic [5:0]  LAST_ROUND = 6'd43;

  state_e      state_q, state_d;
  logic [5:0]  r_q, r_d;
  logic [31:0] x_q, x_d, y_q, y_d;
  logic [31:0] w0_q, w0_d, w1_q, w1_d, w2_q, w2_d, w3_q, w3_d;
  logic [31:0] x_round, k_new, t;

  function automatic logic [31:0] rol(input logic [31:0] v, input int unsigned n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [31:0] ror(input logic [31:0] v, input int unsigned n);
    return (v >> n) | (v << (32 - n));
  endfunction

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    x_d     = x_q;
    y_d     = y_q;
    w0_d    = w0_q;
    w1_d    = w1_q;
    w2_d    = w2_q;
    w3_d    = w3_q;

    x_round = y_q ^ (rol(x_q, 1) & rol(x_q, 8)) ^ rol(x_q, 2) ^ w0_q;
    t       = ror(w3_q, 3) ^ w1_q;
    t       = t ^ ror(t, 1);
    k_new   = ~w0_q ^ t ^ {31'd0, Z[r_q]} ^ 32'h3;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = plaintext[63:32];
          y_d     = plaintext[31:0];
          w0_d    = key[31:0];
          w1_d    = key[63:32];
          w2_d    = key[95:64];
          w3_d    = key[127:96];
          r_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        x_d  = x_round;
        y_d  = x_q;
        w0_d = w1_q;
        w1_d = w2_q;
        w2_d = w3_q;
        w3_d = k_new;
        // r stops at the last round index so DONE still reports it
        if (r_q == LAST_ROUND) begin
          state_d = DONE;
        end else begin
          r_d = r_q + 6'd1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      w0_q    <= '0;
      w1_q    <= '0;
      w2_q    <= '0;
      w3_q    <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      x_q     <= x_d;
      y_q     <= y_d;
      w0_q    <= w0_d;
      w1_q    <= w1_d;
      w2_q    <= w2_d;
      w3_q    <= w3_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign ciphertext = {x_q, y_q};

`ifdef SIMON_RK_TAP_EN
  assign rk_tap = w0_q;
  assign rk_idx = r_q;
`endif

endmodule

// File: tb/tb_simon64_128_encrypt.sv
// Scoreboarded bench for simon64_128_encrypt: KAT, latency/throughput, backpressure,
// busy-ignore, mid-run reset and random vectors against a behavioural SIMON64/128 model.
module tb_simon64_128_encrypt;

  localparam logic [127:0] KAT_KEY = 128'h1b1a1918_13121110_0b0a0908_03020100;
  localparam logic [63:0]  KAT_PT  = 64'h656b696c_20646e75;
  localparam logic [63:0]  KAT_CT  = 64'h44c8fc20_b9dfa07a;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  plaintext;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  ciphertext;
`ifdef SIMON_RK_TAP_EN
  logic [31:0]  rk_tap;
  logic [5:0]   rk_idx;
`endif

  simon64_128_encrypt dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .plaintext  (plaintext),
    .key        (key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ciphertext (ciphertext)
`ifdef SIMON_RK_TAP_EN
    ,
    .rk_tap     (rk_tap),
    .rk_idx     (rk_idx)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  logic [63:0] exp_q[$];
  int          acc_q[$];
  int          acc_log[$];
  logic        ov_prev = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference key schedule, written straight from the SIMON definition.
  function automatic logic [31:0] ref_rk(input logic [127:0] k_in, input int idx);
    logic [31:0] k [0:43];
    logic [31:0] tmp;
    logic [61:0] zc;
    zc = 62'b11011011101011000110010111100000010010001010011100110100001111;
    for (int i = 0; i < 4; i++) k[i] = k_in[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      tmp  = {k[i-1][2:0], k[i-1][31:3]} ^ k[i-3];
      tmp  = tmp ^ {tmp[0], tmp[31:1]};
      k[i] = ~k[i-4] ^ tmp ^ {31'd0, zc[61-(i-4)]} ^ 32'd3;
    end
    return k[idx];
  endfunction

  function automatic logic [63:0] simon_ref(input logic [127:0] k_in, input logic [63:0] p);
    logic [31:0] x, y, tmp;
    x = p[63:32];
    y = p[31:0];
    for (int i = 0; i < 44; i++) begin
      tmp = x;
      x   = y ^ ({x[30:0], x[31]} & {x[23:0], x[31:24]}) ^ {x[29:0], x[31:30]} ^ ref_rk(k_in, i);
      y   = tmp;
    end
    return {x, y};
  endfunction

  always @(posedge clk) cyc++;

  // Output monitor: logs accepts, checks latency and pops the scoreboard on each handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      ov_prev = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        acc_q.push_back(cyc + 1);
        acc_log.push_back(cyc + 1);
      end
      if (out_valid && !ov_prev) begin
        if (acc_q.size() == 0) chk("latency_noaccept", 64'd1, 64'd0);
        else chk("latency", 64'(cyc - acc_q.pop_front() + 1), 64'd45);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("sb_unexpected_output", ciphertext, 64'hx);
        else chk("ciphertext", ciphertext, exp_q.pop_front());
      end
      ov_prev = out_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [127:0] k, input logic [63:0] p, input logic [63:0] e);
    int n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    chk("ready_wait", {63'd0, in_ready}, 64'd1);
    key       = k;
    plaintext = p;
    in_valid  = 1'b1;
    exp_q.push_back(e);
    tick();
    in_valid  = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    chk("idle_wait", {63'd0, in_ready}, 64'd1);
    tick();
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [127:0] rkey;
    logic [63:0]  rpt;
    int n;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    key       = '0;
    plaintext = '0;
    #12;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_ciphertext", ciphertext, 64'd0);
`ifdef SIMON_RK_TAP_EN
    chk("rst_rk_tap", {32'd0, rk_tap}, 64'd0);
    chk("rst_rk_idx", {58'd0, rk_idx}, 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Known-answer job, with round-key tap inspection when the tap is built in.
    start_job(KAT_KEY, KAT_PT, KAT_CT);
`ifdef SIMON_RK_TAP_EN
    for (int j = 0; j < 44; j++) begin
      if (j < 4 || j == 43) begin
        chk($sformatf("rk_tap_%0d", j), {32'd0, rk_tap}, {32'd0, ref_rk(KAT_KEY, j)});
        chk($sformatf("rk_idx_%0d", j), {58'd0, rk_idx}, 64'(j));
      end
      tick();
    end
`endif
    wait_idle();

    // Backpressure: 10 DONE cycles with out_ready low, then handshake.
    out_ready = 1'b0;
    start_job(KAT_KEY, KAT_PT, KAT_CT);
    n = 0;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
    chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold_ct", ciphertext, KAT_CT);
      chk("bp_hold_in_ready", {63'd0, in_ready}, 64'd0);
      chk("bp_hold_out_valid", {63'd0, out_valid}, 64'd1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("bp_idle_in_ready", {63'd0, in_ready}, 64'd1);
    chk("bp_idle_out_valid", {63'd0, out_valid}, 64'd0);
    wait_idle();

    // in_valid with a different block at RUN cycle 20 must be ignored.
    start_job(KAT_KEY, KAT_PT, KAT_CT);
    for (int i = 0; i < 20; i++) tick();
    plaintext = 64'hdead_beef_0bad_f00d;
    key       = ~KAT_KEY;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    wait_idle();

    // Reset at RUN cycle 30 aborts the job; a fresh job follows on the first edge.
    start_job(KAT_KEY, KAT_PT, KAT_CT);
    for (int i = 0; i < 30; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("mrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("mrst_ciphertext", ciphertext, 64'd0);
    exp_q.delete();
    acc_q.delete();
    tick();
    key       = KAT_KEY;
    plaintext = KAT_PT;
    in_valid  = 1'b1;
    exp_q.push_back(KAT_CT);
    #2;
    rst_n = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("mrst_first_accept", {63'd0, in_ready}, 64'd0);
    wait_idle();

    // Back-to-back with in_valid held high.
    n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    key       = KAT_KEY;
    plaintext = KAT_PT;
    in_valid  = 1'b1;
    exp_q.push_back(KAT_CT);
    tick();
    rkey      = {$urandom, $urandom, $urandom, $urandom};
    rpt       = {$urandom, $urandom};
    key       = rkey;
    plaintext = rpt;
    exp_q.push_back(simon_ref(rkey, rpt));
    n = acc_log.size();
    for (int i = 0; i < 200 && acc_log.size() < n + 1; i++) tick();
    in_valid = 1'b0;
    chk("b2b_second_accept", 64'(acc_log.size()), 64'(n + 1));
    if (acc_log.size() >= 2)
      chk("b2b_spacing", 64'(acc_log[acc_log.size()-1] - acc_log[acc_log.size()-2]), 64'd46);
    wait_idle();

    // Random vectors against the model.
    for (int v = 0; v < 3; v++) begin
      rkey = {$urandom, $urandom, $urandom, $urandom};
      rpt  = {$urandom, $urandom};
      start_job(rkey, rpt, simon_ref(rkey, rpt));
      wait_idle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
